// File: rtl/common.sv
// Shared definitions for the multiply/divide unit: ALU op encoding, FSM states,
// iteration counts and small op-decode helpers.
package common;

  localparam int MULDIV_N64 = 64;
  localparam int MULDIV_N32 = 32;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_MUL   = 5'd16,
    ALU_MULW  = 5'd17,
    ALU_DIV   = 5'd18,
    ALU_DIVU  = 5'd19,
    ALU_REM   = 5'd20,
    ALU_REMU  = 5'd21,
    ALU_DIVW  = 5'd22,
    ALU_DIVUW = 5'd23,
    ALU_REMW  = 5'd24,
    ALU_REMUW = 5'd25
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULW};
  endfunction

  function automatic logic is_word(input logic [4:0] op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide (acc = partial remainder, opb shifts dividend out / quotient in).
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] opa_next,
  output logic [XLEN-1:0] opb_next
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
    assign addend[gi] = opb[0] & opa[gi];
  end

  always_comb begin
    shifted  = {acc, opb[XLEN-1]};
    ge       = shifted >= {1'b0, opa};
    // When ge holds the true difference is below opa, so the low bits suffice.
    diff     = shifted[XLEN-1:0] - opa;
    acc_next = acc + addend;
    opa_next = opa << 1;
    opb_next = opb >> 1;
    if (div_mode) begin
      acc_next = ge ? diff : shifted[XLEN-1:0];
      opa_next = opa;
      opb_next = {opb[XLEN-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one radix-2 step per cycle, magnitude
// iteration with sign fix-up on the final edge, single-cycle special cases.
module muldiv_seq
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  muldiv_state_e   state_reg, state_next;
  logic [6:0]      cnt_reg;
  logic [4:0]      op_reg;
  logic [XLEN-1:0] acc_reg, opa_reg, opb_reg, result_reg;
  logic            neg_q_reg, neg_r_reg;

  logic            w_op, s_op, accept, finish, special, div_zero, div_ovf;
  logic            a_neg, b_neg, div_mode;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, dividend_res, sp_result;
  logic [XLEN-1:0] step_acc, step_opa, step_opb, q_fix, r_fix, fin;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Operand decode for the incoming operation.
  always_comb begin
    w_op  = is_word(op);
    s_op  = is_signed_div(op);
    a_ext = a;
    b_ext = b;
    if (w_op) begin
      a_ext = s_op ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]};
      b_ext = s_op ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]};
    end
    a_neg        = s_op & a_ext[XLEN-1];
    b_neg        = s_op & b_ext[XLEN-1];
    a_mag        = a_neg ? -a_ext : a_ext;
    b_mag        = b_neg ? -b_ext : b_ext;
    min_val      = w_op ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero     = !is_mul(op) && (b_ext == '0);
    div_ovf      = s_op && (a_ext == min_val) && (b_ext == '1);
    special      = div_zero | div_ovf;
    dividend_res = w_op ? sext32(a[31:0]) : a;
    if (is_rem(op)) sp_result = div_zero ? dividend_res : '0;
    else            sp_result = div_zero ? '1 : dividend_res;
  end

  assign div_mode = !is_mul(op_reg);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (div_mode),
    .acc      (acc_reg),
    .opa      (opa_reg),
    .opb      (opb_reg),
    .acc_next (step_acc),
    .opa_next (step_opa),
    .opb_next (step_opb)
  );

  // Final-edge result: sign fix-up and W sign extension.
  always_comb begin
    q_fix = neg_q_reg ? -step_opb : step_opb;
    r_fix = neg_r_reg ? -step_acc : step_acc;
    if (is_mul(op_reg))      fin = step_acc;
    else if (is_rem(op_reg)) fin = r_fix;
    else                     fin = q_fix;
    if (is_word(op_reg)) fin = sext32(fin[31:0]);
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = resetn && !flush;
        accept   = in_valid && in_ready && is_muldiv(op);
        if (accept) state_next = special ? DONE : CALC;
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == 7'd1) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE: begin
        if (flush || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg    <= '0;
      op_reg     <= '0;
      acc_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else if (accept) begin
      op_reg    <= op;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      acc_reg   <= '0;
      if (special) begin
        cnt_reg    <= '0;
        result_reg <= sp_result;
      end else begin
        cnt_reg <= w_op ? 7'(MULDIV_N32) : 7'(MULDIV_N64);
        if (is_mul(op)) begin
          opa_reg <= a_ext;
          opb_reg <= b_ext;
        end else begin
          // W dividends start in the upper half so bits leave MSB-first.
          opa_reg <= b_mag;
          opb_reg <= w_op ? (a_mag << 32) : a_mag;
        end
      end
    end else if (state_reg == CALC) begin
      if (flush) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg - 7'd1;
        acc_reg <= step_acc;
        opa_reg <= step_opa;
        opb_reg <= step_opb;
        if (finish) result_reg <= fin;
      end
    end
  end

  assign out_valid = (state_reg == DONE) && !flush;
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: scoreboard of expected results, latency,
// hold, flush and reset behaviour.
module tb_muldiv_seq;
  import common::*;

  logic        clk = 1'b0;
  logic        resetn, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [63:0] a, b, result;
  logic [63:0] ra, rb;
  logic [63:0] exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          seen;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Presents an op for one cycle; returns #1 after the acceptance edge.
  task automatic drive(input logic [4:0] o, input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] o, input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] ex);
    drive(o, av, bv);
    exp_q.push_back(ex);
  endtask

  // lat = rising edges after the acceptance edge until out_valid is seen.
  task automatic wait_result(input string tag, input int lat, input int hold);
    int k = 0;
    logic [63:0] ex;
    while (out_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ":valid"}, 64'(out_valid), 64'd1);
    check({tag, ":latency"}, 64'(k), 64'(lat));
    ex = exp_q.pop_front();
    check({tag, ":result"}, result, ex);
    $display("%s: result 0x%h expected 0x%h after %0d cycles", tag, result, ex, k);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_result"}, result, ex);
      check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_busy"}, 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ":idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:in_ready", 64'(in_ready), 64'd0);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:result", result, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle:in_ready", 64'(in_ready), 64'd1);

    issue(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_result("MUL 3*-5", 64, 0);
    issue(ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_result("DIV -7/2", 64, 0);
    issue(ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_result("REM -7/2", 64, 0);

    // Special cases complete on the acceptance edge itself.
    issue(ALU_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_result("DIVU 5/0", 0, 0);
    issue(ALU_REMU, 64'd5, 64'd0, 64'd5);
    wait_result("REMU 5/0", 0, 0);
    issue(ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    wait_result("DIV min/-1", 0, 0);
    issue(ALU_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    wait_result("DIVW min/-1", 0, 0);
    issue(ALU_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    wait_result("REMW min/-1", 0, 0);
    issue(ALU_REMUW, 64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005);
    wait_result("REMUW x/0", 0, 0);

    issue(ALU_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_result("MULW hold", 32, 5);
    issue(ALU_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF);
    wait_result("DIVUW", 32, 0);

    // Non-muldiv op must be ignored.
    drive(ALU_ADD, 64'd1, 64'd2);
    repeat (3) @(posedge clk);
    #1;
    check("alu_add:busy", 64'(busy), 64'd0);
    check("alu_add:out_valid", 64'(out_valid), 64'd0);

    // Flush on the tenth cycle of a DIV, then flush together with in_valid.
    drive(ALU_DIV, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    check("flush:busy", 64'(busy), 64'd0);
    op = ALU_DIVU; a = 64'd9; b = 64'd3; in_valid = 1'b1;
    #1 check("flush:in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_valid:busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush:no_out_valid", 64'(seen), 64'd0);

    issue(ALU_DIVU, 64'd100, 64'd7, 64'd14);
    wait_result("DIVU 100/7", 64, 0);

    // Reset pulsed mid-MUL discards the operation immediately.
    drive(ALU_MUL, 64'd7, 64'd9);
    repeat (20) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst:out_valid", 64'(out_valid), 64'd0);
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:in_ready", 64'(in_ready), 64'd0);
    check("midrst:result", result, 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    issue(ALU_DIVW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);
    wait_result("DIVW -100/7", 32, 0);
    issue(ALU_REMW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_result("REMW -100/7", 32, 0);

    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = ({$urandom, $urandom} >> (8 * i)) | 64'd1;
      issue(ALU_MUL, ra, rb, ra * rb);
      wait_result($sformatf("MUL rand%0d", i), 64, 0);
      issue(ALU_DIVU, ra, rb, ra / rb);
      wait_result($sformatf("DIVU rand%0d", i), 64, 0);
      issue(ALU_REM, ra, rb, $signed(ra) % $signed(rb));
      wait_result($sformatf("REM rand%0d", i), 64, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
